// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: gathers 1-3 byte instructions from the program bus and hands a
// complete bundle to the control unit. Define IFU_ILLEGAL_TRAP_EN to trap on zero length.
module instr_fetch_unit #(
    parameter int unsigned              ADDR_WIDTH   = 16,
    parameter int unsigned              DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0]    RESET_VECTOR = 16'hF000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_req,
    input  logic                  mem_rd_valid,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] len_opcode,
    input  logic [1:0]            len_bytes,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_opcode,
    output logic [DATA_WIDTH-1:0] instr_op1,
    output logic [DATA_WIDTH-1:0] instr_op2,
    output logic [1:0]            instr_len,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  redirect_en,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic                  halt,
    output logic                  illegal_o
);

    typedef enum logic [2:0] {
        StIdle,
        StReqOp,
        StReqB1,
        StReqB2,
        StPresent,
        StHalted
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q;
    logic                    drop_q;
    logic                    illegal_q;
    logic                    in_req;
    logic                    byte_ok;
    logic                    transfer;
    logic [1:0]              len_eff;
    logic [ADDR_WIDTH-1:0]   pc_inc;

    assign in_req     = (state_q == StReqOp) || (state_q == StReqB1) || (state_q == StReqB2);
    // drop_q masks the request for one cycle so a late response to the flushed read is ignored
    assign mem_rd_req = in_req && !drop_q;
    assign mem_addr   = mem_rd_req ? fetch_pc_q : '0;
    assign len_opcode = mem_rd_data;
    assign byte_ok    = mem_rd_valid && mem_rd_req;
    assign transfer   = (state_q == StPresent) && instr_valid && instr_ready;
    assign pc_inc     = fetch_pc_q + ADDR_WIDTH'(1);
    assign illegal_o  = illegal_q;

    always_comb begin
`ifdef IFU_ILLEGAL_TRAP_EN
        len_eff = len_bytes;
`else
        len_eff = (len_bytes == 2'd0) ? 2'd1 : len_bytes;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            fetch_pc_q   <= RESET_VECTOR;
            drop_q       <= 1'b0;
            illegal_q    <= 1'b0;
            instr_valid  <= 1'b0;
            instr_opcode <= '0;
            instr_op1    <= '0;
            instr_op2    <= '0;
            instr_len    <= 2'd0;
            instr_pc     <= '0;
        end else begin
            drop_q <= 1'b0;
            if (state_q == StHalted) begin
                instr_valid <= 1'b0;
            end else if (halt) begin
                // A bundle already on offer is allowed to complete before halting
                if (!(state_q == StPresent && instr_valid && !instr_ready)) begin
                    state_q     <= StHalted;
                    instr_valid <= 1'b0;
                end
            end else if (redirect_en) begin
                fetch_pc_q  <= redirect_addr;
                instr_valid <= 1'b0;
                state_q     <= StReqOp;
                drop_q      <= in_req;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StReqOp;
                    end
                    StReqOp: begin
                        if (byte_ok) begin
                            instr_opcode <= mem_rd_data;
                            instr_op1    <= '0;
                            instr_op2    <= '0;
                            instr_pc     <= fetch_pc_q;
                            instr_len    <= len_eff;
                            fetch_pc_q   <= pc_inc;
                            if (len_eff == 2'd0) begin
                                illegal_q <= 1'b1;
                                state_q   <= StHalted;
                            end else if (len_eff == 2'd1) begin
                                state_q <= StPresent;
                            end else begin
                                state_q <= StReqB1;
                            end
                        end
                    end
                    StReqB1: begin
                        if (byte_ok) begin
                            instr_op1  <= mem_rd_data;
                            fetch_pc_q <= pc_inc;
                            state_q    <= (instr_len == 2'd2) ? StPresent : StReqB2;
                        end
                    end
                    StReqB2: begin
                        if (byte_ok) begin
                            instr_op2  <= mem_rd_data;
                            fetch_pc_q <= pc_inc;
                            state_q    <= StPresent;
                        end
                    end
                    StPresent: begin
                        // First PRESENT cycle raises valid; the bundle is then held until taken
                        if (!instr_valid) begin
                            instr_valid <= 1'b1;
                        end else if (transfer) begin
                            instr_valid <= 1'b0;
                            state_q     <= StReqOp;
                        end
                    end
                    default: begin
                        state_q <= StHalted;
                    end
                endcase
            end
        end
    end

endmodule
